// File: rtl/claswp_pivot_feeder.sv
// Walks a 1-based int32 pivot array in LAPACK order over a 64-bit Avalon-MM read master
// and streams only the non-trivial (row, pivot_row) swap pairs to the row-swap engine.
module claswp_pivot_feeder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        stall,
    output logic [31:0] returndata,
    input  logic [63:0] k1,
    input  logic [63:0] k2,
    input  logic [63:0] incx,
    input  logic [63:0] ipiv,
    output logic [63:0] avmm_0_r_address,
    output logic [7:0]  avmm_0_r_byteenable,
    output logic        avmm_0_r_read,
    input  logic        avmm_0_r_waitrequest,
    input  logic [63:0] avmm_0_r_readdata,
    input  logic        avmm_0_r_readdatavalid,
    output logic        pivot_valid,
    input  logic        pivot_stall,
    output logic [31:0] pivot_row,
    output logic [31:0] pivot_src
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        rd_q, rd_d;
    logic        pend_q, pend_d;
    logic [63:0] addr_q, addr_d;
    logic        sel_q, sel_d;
    logic [63:0] ix_q, ix_d;
    logic [63:0] incx_q, incx_d;
    logic [63:0] ipiv_q, ipiv_d;
    logic [31:0] row_q, row_d;
    logic        asc_q, asc_d;
    logic [32:0] left_q, left_d;
    logic [31:0] swaps_q, swaps_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [31:0] fifo_row_q [FIFO_DEPTH];
    logic [31:0] fifo_src_q [FIFO_DEPTH];

    // Only the low 32 bits of the LAPACK ints carry meaning.
    logic unused_hi;
    assign unused_hi = ^{k1[63:32], k2[63:32], incx[63:32]};

    logic        dir_up, zero_iter;
    logic [63:0] k1_ext, k2_ext, incx_ext, ix_start, e_start, ix_adv, e_adv;
    logic [31:0] half;
    logic        accept, complete, push, pop;

    assign dir_up    = $signed(incx[31:0]) > 32'sd0;
    assign zero_iter = (incx[31:0] == 32'd0) || ($signed(k1[31:0]) > $signed(k2[31:0]));
    assign k1_ext    = {{32{k1[31]}}, k1[31:0]};
    assign k2_ext    = {{32{k2[31]}}, k2[31:0]};
    assign incx_ext  = {{32{incx[31]}}, incx[31:0]};
    // Two's-complement wraps make unsigned 64-bit arithmetic match the signed formula.
    assign ix_start  = dir_up ? k1_ext : 64'd1 + (64'd1 - k2_ext) * incx_ext;
    assign e_start   = ipiv + ((ix_start - 64'd1) << 2);
    assign ix_adv    = ix_q + incx_q;
    assign e_adv     = ipiv_q + ((ix_adv - 64'd1) << 2);

    assign half      = sel_q ? avmm_0_r_readdata[63:32] : avmm_0_r_readdata[31:0];
    assign accept    = rd_q & ~avmm_0_r_waitrequest;
    assign complete  = pend_q & avmm_0_r_readdatavalid;
    assign push      = complete && (half != row_q);
    assign pop       = pivot_valid & ~pivot_stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            rd_q    <= 1'b0;
            pend_q  <= 1'b0;
            addr_q  <= '0;
            sel_q   <= 1'b0;
            ix_q    <= '0;
            incx_q  <= '0;
            ipiv_q  <= '0;
            row_q   <= '0;
            asc_q   <= 1'b0;
            left_q  <= '0;
            swaps_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            ix_q    <= ix_d;
            incx_q  <= incx_d;
            ipiv_q  <= ipiv_d;
            row_q   <= row_d;
            asc_q   <= asc_d;
            left_q  <= left_d;
            swaps_q <= swaps_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_row_q[wptr_q] <= row_q;
            fifo_src_q[wptr_q] <= half;
        end
    end

    always_comb begin
        wptr_d = wptr_q + AW'(push);
        rptr_d = rptr_q + AW'(pop);
        fcnt_d = fcnt_q + CW'(push) - CW'(pop);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN: begin
                if (complete && left_q == 33'd1) state_d = S_DRAIN;
                // Nothing to fetch and nothing buffered: skip straight to the return.
                else if (left_q == 33'd0)        state_d = S_DONE;
            end
            S_DRAIN: if (fcnt_q == '0) state_d = S_DONE;
            S_DONE:  if (!stall) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Walk and read-master datapath
    always_comb begin
        rd_d    = 1'b0;
        pend_d  = 1'b0;
        addr_d  = addr_q;
        sel_d   = sel_q;
        ix_d    = ix_q;
        incx_d  = incx_q;
        ipiv_d  = ipiv_q;
        row_d   = row_q;
        asc_d   = asc_q;
        left_d  = left_q;
        swaps_d = swaps_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    incx_d  = incx_ext;
                    ipiv_d  = ipiv;
                    ix_d    = ix_start;
                    row_d   = dir_up ? k1[31:0] : k2[31:0];
                    asc_d   = dir_up;
                    left_d  = zero_iter ? 33'd0
                                        : {k2[31], k2[31:0]} - {k1[31], k1[31:0]} + 33'd1;
                    swaps_d = '0;
                    addr_d  = {e_start[63:3], 3'b000};
                    sel_d   = e_start[2];
                    rd_d    = ~zero_iter;
                end
            end
            S_RUN: begin
                rd_d   = rd_q & avmm_0_r_waitrequest;
                pend_d = (pend_q & ~avmm_0_r_readdatavalid) | accept;
                if (complete) begin
                    ix_d    = ix_adv;
                    row_d   = asc_q ? row_q + 32'd1 : row_q - 32'd1;
                    left_d  = left_q - 33'd1;
                    addr_d  = {e_adv[63:3], 3'b000};
                    sel_d   = e_adv[2];
                    if (push) swaps_d = swaps_q + 32'd1;
                end
                // One read in flight at most, and only when its data is sure to fit.
                if (!rd_q && (!pend_q || complete) && left_d != 33'd0 &&
                    fcnt_d < CW'(FIFO_DEPTH))
                    rd_d = 1'b1;
            end
            default: ;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        returndata = (state_q == S_DONE) ? swaps_q : 32'd0;
    end

    assign avmm_0_r_address    = addr_q;
    assign avmm_0_r_byteenable = 8'hFF;
    assign avmm_0_r_read       = rd_q;
    assign pivot_valid         = (fcnt_q != '0);
    assign pivot_row           = pivot_valid ? fifo_row_q[rptr_q] : 32'd0;
    assign pivot_src           = pivot_valid ? fifo_src_q[rptr_q] : 32'd0;

endmodule

// File: doc/claswp_pivot_feeder.md
# claswp_pivot_feeder

Upstream companion to the `claswp` row-swap component in the LAPACK-lite HLS flow. It walks the 1-based int32 pivot array `ipiv` in LAPACK order for a given `k1`, `k2` and `incx`, and fetches entries over its own 64-bit Avalon-MM read master. It emits only the non-trivial `(row, pivot_row)` swap pairs on a valid/stall stream for the swap engine to consume. It uses the same call/return handshake as the rest of the generated components.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: output buffer entries, power of two, ≥2.

Ports:
- `clock`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  call.valid.
- `busy`  out  1  call.stall; high whenever the block is not in IDLE.
- `done`  out  1  return.valid.
- `stall`  in  1  return.stall.
- `returndata`  out  32  number of swap pairs emitted.
- `k1`, `k2`, `incx`  in  64 each  LAPACK ints; only bits [31:0] are used, read as signed.
- `ipiv`  in  64  byte base address of the pivot array.
- `avmm_0_r_address`  out  64  8-byte-aligned word address.
- `avmm_0_r_byteenable`  out  8  always 8'hFF.
- `avmm_0_r_read`  out  1  read request.
- `avmm_0_r_waitrequest`  in  1  slave stall.
- `avmm_0_r_readdata`  in  64  read data.
- `avmm_0_r_readdatavalid`  in  1  read data valid.
- `pivot_valid`  out  1  swap pair available.
- `pivot_stall`  in  1  consumer back-pressure.
- `pivot_row`  out  32  row i (1-based).
- `pivot_src`  out  32  ipiv value for row i (1-based).

## Operation
- Arguments are latched on `start` while in IDLE. `start` while `busy` is ignored.
- Iteration order:
  - `incx > 0`: i = k1..k2 ascending, starting at ix = k1.
  - `incx < 0`: i = k2..k1 descending, starting at ix = 1 + (1-k2)*incx.
  - ix advances by `incx` each step.
  - `incx == 0` or `k1 > k2`: zero iterations.
- Element address: E = ipiv + 4*(ix-1), computed in 64-bit signed arithmetic.
  - Bus address = E & ~7.
  - Selected half: `readdata[31:0]` if E[2]=0, else `readdata[63:32]`. Data is little-endian.
- Filtering: when the fetched value p ≠ i, push (i, p) into the FIFO and increment the swap count. When p == i, drop the entry.
- At most one outstanding read. A read is issued only if the FIFO has at least one free slot after counting the in-flight read, so returned data is never lost.
- FSM:
  - IDLE → RUN on `start`.
  - RUN: issue reads. Move to DRAIN once the last read's data has returned.
  - DRAIN → DONE when the FIFO is empty.
  - DONE: `done`=1, `returndata` = count. Return to IDLE in the first cycle with `stall`=0.
- `reset`, including mid-operation, returns the block to IDLE immediately. It flushes the FIFO, clears the count, and drops the in-flight read, so its late `readdatavalid` is ignored. Reset is applied only while the bus is idle or flushed by the system.

## Timing
- Reset values: `busy`=0, `done`=0, `returndata`=0, `avmm_0_r_read`=0, `avmm_0_r_address`=0, `pivot_valid`=0, `pivot_row`=0, `pivot_src`=0.
- First RUN cycle (cycle after `start`): `avmm_0_r_read` is asserted. It is held with a stable address while `waitrequest`=1.
- Next read is issued no earlier than the cycle after the previous `readdatavalid`.
- FIFO push occurs on the `readdatavalid` cycle. `pivot_valid` rises the following cycle.
- Stream handshake: a pair transfers in each cycle with `pivot_valid`=1 and `pivot_stall`=0. While stalled, `pivot_row` and `pivot_src` hold stable.
- Simultaneous push and pop with a full FIFO is allowed.
- Zero iterations: `done`=1 exactly two cycles after `start`, with `returndata`=0 and no bus read.
- `done` rises the cycle after the FIFO empties. It stays high while `stall`=1. Because `busy` remains high in DONE, a new `start` can be accepted no earlier than the cycle after `done` drops.

## Test plan
- k1=1, k2=4, incx=1, ipiv at 0x1000 = {3,2,4,4}, zero-latency memory → reads at 0x1000 and 0x1008 (twice each), pairs (1,3) and (3,4), `returndata`=2.
- Same array with incx=-1 → order i=4,3,2,1, pairs (3,4) then (1,3), `returndata`=2.
- k1=3, k2=2 → no `avmm_0_r_read`; `done` two cycles after `start`, `returndata`=0. Repeat with incx=0: same result.
- ipiv={2,1,4,3}, `pivot_stall` held high for 20 cycles → at most FIFO_DEPTH pairs buffered, no read issued while full. After release, all 4 pairs arrive in order with no loss.
- `waitrequest` randomized, read latency 1–5 cycles, 64 entries at base 0x2004 (odd word) → correct half-word selection everywhere; count matches a software model.
- Assert `reset` mid-RUN with a read in flight → next cycle all outputs at reset values; the stray `readdatavalid` is ignored; a following call with ipiv={1} returns 0.
